// File: rtl/demux_1to8_seq_pkg.sv
// Shared constants and helpers for the 1-to-8 sequential demultiplexer.
// Width and way-count live here so the decoder and top agree.
package demux_1to8_seq_pkg;

  localparam int DEMUX_WAYS = 8;
  localparam int SEL_W      = 3;

  localparam logic [DEMUX_WAYS-1:0] MASK_ALL  = {DEMUX_WAYS{1'b1}};
  localparam logic [DEMUX_WAYS-1:0] MASK_NONE = '0;

  // Auto pointer advance; wraps 7 -> 0 through natural truncation.
  function automatic logic [SEL_W-1:0] ptr_next(input logic [SEL_W-1:0] p);
    return p + {{(SEL_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/demux_1to8_seq_dec_3to8.sv
// Index-to-one-hot decoder with enable.
// The one-hot output is used both as Y write enables and as mask set enables.
module dec_3to8
  import demux_1to8_seq_pkg::*;
(
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  output logic [DEMUX_WAYS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_1to8_seq.sv
// Sequential 1-to-8 demultiplexer: routes one serial bit per load into Y,
// tracks which indices were written this frame, and pulses done on completion.
module demux_1to8_seq
  import demux_1to8_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  D,
  input  logic                  S2,
  input  logic                  S1,
  input  logic                  S0,
  input  logic                  load,
  input  logic                  auto,
  input  logic                  clr,
  output logic [DEMUX_WAYS-1:0] Y,
  output logic [SEL_W-1:0]      ptr,
  output logic                  done,
  output logic [DEMUX_WAYS-1:0] w_mask_dbg
);

  // load is a one-cycle write strobe with no backpressure: every edge with
  // load=1 and clr=0 is accepted; there is no ready signal to wait on.

  logic [DEMUX_WAYS-1:0] y_q, y_d;
  logic [DEMUX_WAYS-1:0] w_q, w_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;
  logic                  done_q, done_d;

  logic [SEL_W-1:0]      dest;
  logic [DEMUX_WAYS-1:0] we;
  logic [DEMUX_WAYS-1:0] w_set;

  assign dest = auto ? ptr_q : {S2, S1, S0};

  dec_3to8 u_dec (
    .en     (load),
    .sel    (dest),
    .onehot (we)
  );

  assign w_set = w_q | we;

  always_comb begin
    y_d    = y_q;
    w_d    = w_q;
    ptr_d  = ptr_q;
    done_d = 1'b0;
    if (clr) begin
      y_d   = '0;
      w_d   = MASK_NONE;
      ptr_d = '0;
    end else if (load) begin
      y_d = (y_q & ~we) | ({DEMUX_WAYS{D}} & we);
      // Completing the frame clears the mask on the same edge that raises done.
      if (w_set == MASK_ALL) begin
        w_d    = MASK_NONE;
        done_d = 1'b1;
      end else begin
        w_d = w_set;
      end
      if (auto) begin
        ptr_d = ptr_next(ptr_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      w_q    <= MASK_NONE;
      ptr_q  <= '0;
      done_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      w_q    <= w_d;
      ptr_q  <= ptr_d;
      done_q <= done_d;
    end
  end

  assign Y          = y_q;
  assign ptr        = ptr_q;
  assign done       = done_q;
  assign w_mask_dbg = w_q;

endmodule

// File: tb/tb_demux_1to8_seq.sv
// Self-checking bench for demux_1to8_seq: vector table, directed corner
// sequences and a randomized run against a behavioural frame model.
module tb_demux_1to8_seq;

  logic       clk;
  logic       rst_n;
  logic       D, S2, S1, S0, load, auto, clr;
  logic [7:0] Y;
  logic [2:0] ptr;
  logic       done;
  logic [7:0] w_mask_dbg;

  int total = 0;
  int bad   = 0;

  demux_1to8_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .D          (D),
    .S2         (S2),
    .S1         (S1),
    .S0         (S0),
    .load       (load),
    .auto       (auto),
    .clr        (clr),
    .Y          (Y),
    .ptr        (ptr),
    .done       (done),
    .w_mask_dbg (w_mask_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_y[8];
  bit m_written[8];
  int m_count;
  int m_ptr;
  bit m_done;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_y[i]       = 1'b0;
      m_written[i] = 1'b0;
    end
    m_count = 0;
    m_ptr   = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step(input bit d, input int s, input bit ld, input bit au, input bit cl);
    int dest;
    m_done = 1'b0;
    if (cl) begin
      model_reset();
    end else if (ld) begin
      dest = au ? m_ptr : s;
      m_y[dest] = d;
      if (!m_written[dest]) begin
        m_written[dest] = 1'b1;
        m_count++;
      end
      if (m_count == 8) begin
        m_done = 1'b1;
        m_count = 0;
        for (int i = 0; i < 8; i++) m_written[i] = 1'b0;
      end
      if (au) m_ptr = (m_ptr + 1) % 8;
    end
  endtask

  function automatic logic [7:0] model_y();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_y[i];
    return v;
  endfunction

  function automatic logic [7:0] model_w();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_written[i];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    check({name, ".Y"},    {24'd0, Y},          {24'd0, model_y()});
    check({name, ".ptr"},  {29'd0, ptr},        m_ptr);
    check({name, ".done"}, {31'd0, done},       {31'd0, m_done});
    check({name, ".w"},    {24'd0, w_mask_dbg}, {24'd0, model_w()});
  endtask

  // ---------------- drivers ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic cycle(input bit d, input logic [2:0] s, input bit ld, input bit au, input bit cl);
    D    = d;
    {S2, S1, S0} = s;
    load = ld;
    auto = au;
    clr  = cl;
    @(posedge clk);
    #1;
    model_step(d, int'(s), ld, au, cl);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    D = 0; {S2, S1, S0} = 3'd0; load = 0; auto = 0; clr = 0;
    model_reset();
    #1;
    check("reset.Y", {24'd0, Y}, 32'h0);
    check("reset.ptr", {29'd0, ptr}, 32'h0);
    check("reset.done", {31'd0, done}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       d;
    logic [2:0] s;
    logic       ld;
    logic       au;
    logic       cl;
    logic [7:0] y;
    logic [2:0] p;
    logic       dn;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Eight auto loads (S ignored), then two idle cycles that must hold.
    tbl[0] = '{1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 8'h01, 3'd1, 1'b0};
    tbl[1] = '{1'b0, 3'd6, 1'b1, 1'b1, 1'b0, 8'h01, 3'd2, 1'b0};
    tbl[2] = '{1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 8'h05, 3'd3, 1'b0};
    tbl[3] = '{1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 8'h0D, 3'd4, 1'b0};
    tbl[4] = '{1'b0, 3'd6, 1'b1, 1'b1, 1'b0, 8'h0D, 3'd5, 1'b0};
    tbl[5] = '{1'b0, 3'd6, 1'b1, 1'b1, 1'b0, 8'h0D, 3'd6, 1'b0};
    tbl[6] = '{1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 8'h4D, 3'd7, 1'b0};
    tbl[7] = '{1'b0, 3'd6, 1'b1, 1'b1, 1'b0, 8'h4D, 3'd0, 1'b1};
    tbl[8] = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 8'h4D, 3'd0, 1'b0};
    tbl[9] = '{1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 8'h4D, 3'd0, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b1;
    D = 0; {S2, S1, S0} = 3'd0; load = 0; auto = 0; clr = 0;
    #2;
    do_reset();

    // Table-driven auto frame
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].d, tbl[i].s, tbl[i].ld, tbl[i].au, tbl[i].cl);
      check($sformatf("tbl%0d.Y", i),    {24'd0, Y},    {24'd0, tbl[i].y});
      check($sformatf("tbl%0d.ptr", i),  {29'd0, ptr},  {29'd0, tbl[i].p});
      check($sformatf("tbl%0d.done", i), {31'd0, done}, {31'd0, tbl[i].dn});
    end

    // Explicit load to index 5, then repeated rewrites of the same index
    do_reset();
    cycle(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
    check("expl.Y", {24'd0, Y}, 32'h20);
    check("expl.ptr", {29'd0, ptr}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
      check("rewrite.Y", {24'd0, Y}, 32'h20);
      check("rewrite.done", {31'd0, done}, 32'h0);
    end
    check("rewrite.w", {24'd0, w_mask_dbg}, 32'h20);

    // Mixed auto and explicit writes share one frame
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
      check("mix.auto.done", {31'd0, done}, 32'h0);
    end
    check("mix.auto.Y", {24'd0, Y}, 32'h0F);
    check("mix.auto.ptr", {29'd0, ptr}, 32'h4);
    for (int i = 4; i < 8; i++) begin
      cycle(1'b0, 3'(i), 1'b1, 1'b0, 1'b0);
      check($sformatf("mix.expl%0d.done", i), {31'd0, done}, (i == 7) ? 32'h1 : 32'h0);
    end
    check("mix.expl.ptr", {29'd0, ptr}, 32'h4);
    cycle(1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    check("mix.after.Y", {24'd0, Y}, 32'h1F);
    check("mix.after.ptr", {29'd0, ptr}, 32'h5);
    check("mix.after.done", {31'd0, done}, 32'h0);

    // clr beats load, even on the edge that would complete a frame
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 3'd0, 1'b1, 1'b1, 1'b1);
    check("clr.Y", {24'd0, Y}, 32'h0);
    check("clr.ptr", {29'd0, ptr}, 32'h0);
    check("clr.done", {31'd0, done}, 32'h0);
    check("clr.w", {24'd0, w_mask_dbg}, 32'h0);
    cycle(1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    check("postclr.Y", {24'd0, Y}, 32'h01);
    check("postclr.w", {24'd0, w_mask_dbg}, 32'h01);

    // Asynchronous reset between edges discards a partial frame
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    check("pre_arst.Y", {24'd0, Y}, 32'h3F);
    check("pre_arst.ptr", {29'd0, ptr}, 32'h6);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.Y", {24'd0, Y}, 32'h0);
    check("arst.ptr", {29'd0, ptr}, 32'h0);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
      check($sformatf("arst.load%0d.done", i), {31'd0, done}, (i == 7) ? 32'h1 : 32'h0);
    end
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    check("arst.pulse_end.done", {31'd0, done}, 32'h0);

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rand.arst.Y", {24'd0, Y}, 32'h0);
        rst_n = 1'b1;
      end
      cycle(1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 39) == 0));
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_1to8_seq.md
DEMUX_1TO8_SEQ -- requirements
Module: demux_1to8_seq

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 D  input  1  serial data bit to be routed.
REQ-004 S2, S1, S0  input  1 each  explicit destination select (S2 = MSB), used when auto=0.
REQ-005 load  input  1  write strobe; one bit routed per cycle with load=1.
REQ-006 auto  input  1  1 = destination from internal pointer; 0 = destination from S2..S0.
REQ-007 clr  input  1  synchronous clear of outputs, mask, pointer and flags.
REQ-008 Y  output  8  registered demultiplexed outputs; Y[i] holds the last bit routed to index i.
REQ-009 ptr  output  3  current auto-mode pointer.
REQ-010 done  output  1  one-cycle pulse when all 8 indices have been written since the last frame boundary.

Function
REQ-011 The destination index SHALL be {S2,S1,S0} when auto=0 and ptr when auto=1, sampled on the same clk edge as load.
REQ-012 On a clk edge with load=1 and clr=0, Y[dest] SHALL take D; all other Y bits hold. Y changes exactly one cycle after load is sampled.
REQ-013 With load=0 and clr=0, Y, ptr and the written mask SHALL hold.
REQ-014 An internal 8-bit written mask W SHALL set W[dest] on every accepted load. Rewriting an already-set index overwrites Y[dest] and leaves W unchanged.
REQ-015 On an accepted load with auto=1, ptr SHALL increment by 1 modulo 8 (7 -> 0). ptr SHALL NOT change when auto=0.
REQ-016 On the edge where an accepted load makes W all ones, done SHALL be 1 for the following cycle only, and W SHALL clear to 0 on that same edge. Y and ptr are unaffected.
REQ-017 done SHALL be 0 in every cycle not covered by REQ-016.
REQ-018 clr=1 SHALL take priority over load: on that edge Y=0, W=0, ptr=0 and done=0, and D is discarded.
REQ-019 Toggling auto mid-frame SHALL preserve ptr and W. Mixed explicit and auto writes contribute to the same frame.
REQ-020 Ports S2..S0 SHALL be ignored when auto=1. D, S2..S0 and auto SHALL be ignored when load=0.

Reset
REQ-021 rst_n=0 SHALL immediately, independent of clk, force Y=8'h00, W=0, ptr=0 and done=0.
REQ-022 After rst_n deasserts, the first accepted load SHALL behave exactly as a load following clr.
REQ-023 A reset asserted mid-frame SHALL discard the partial frame; no done pulse results from writes made before the reset.

Structure
REQ-024 A shared package SHALL hold the constants DEMUX_WAYS=8 and SEL_W=3 and the all-ones mask constant.
REQ-025 Index-to-one-hot decoding SHALL be a sub-module dec_3to8 (3-bit in, 8-bit one-hot out, enable). Its output drives both the Y write enables and the W set enables.
REQ-026 All state (Y, W, ptr, done) SHALL reside in demux_1to8_seq in a single clocked process with asynchronous reset.

Verification
REQ-027 Reset then auto=1, load=1 for 8 cycles with D=1,0,1,1,0,0,1,0 -> Y=8'b01001101, ptr returns to 0, done=1 exactly in the cycle after the 8th load.
REQ-028 auto=0, S=3'b101, D=1, one load -> Y=8'h20 next cycle. Then three more loads to S=5 -> no done, Y unchanged.
REQ-029 auto=1 with 4 loads, auto=0 with explicit loads to indices 4..7 -> done pulses once after the 8th distinct index. A following single auto load writes Y[4] (ptr=4).
REQ-030 clr=1 and load=1 on the same edge with auto=1 -> Y=0, ptr=0, no write, no done.
REQ-031 rst_n pulsed low between clk edges after 6 auto loads -> Y=0 and ptr=0 immediately. 8 further loads are needed before done asserts.
REQ-032 Randomized 1000-cycle run checked against a reference model that applies REQ-011 to REQ-020 -> Y, ptr and done match every cycle.
